// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the CPU bus arbiter: state encoding, requester
// indices, parameter defaults and the counter-width helper.
package cpu_bus_pkg;

    localparam int DRAIN_CYC_DEFAULT = 2;
    localparam int MAX_BURST_DEFAULT = 16;
    localparam int CPU_MIN_DEFAULT   = 4;

    // Requester bit positions within REQ / GNT.
    localparam int REQ_DMA  = 0;
    localparam int REQ_UART = 1;

    // Arbiter states; the encoding is visible on the ARB_STATE debug port.
    typedef enum logic [2:0] {
        ST_CPU     = 3'd0,
        ST_DRAIN   = 3'd1,
        ST_GRANT   = 3'd2,
        ST_RELEASE = 3'd3,
        ST_HOLDOFF = 3'd4
    } arb_state_e;

    // Width of the phase counter: wide enough for the longest phase plus a
    // spare bit so saturation never aliases a terminal count.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker. ptr names the requester granted last
// (1 = UART), so on a tie the other one wins. Output is zero unless update.
module rr_arb2
    import cpu_bus_pkg::*;
(
    input  logic [1:0] req,
    input  logic       ptr,
    input  logic       update,
    output logic [1:0] gnt
);

    // Pick a one-hot winner only when the parent is arbitrating this cycle.
    always_comb begin
        gnt = 2'b00;
        if (update) begin
            case (req)
                2'b01:   gnt[REQ_DMA]  = 1'b1;
                2'b10:   gnt[REQ_UART] = 1'b1;
                2'b11: begin
                    if (ptr) gnt[REQ_DMA]  = 1'b1;
                    else     gnt[REQ_UART] = 1'b1;
                end
                default: gnt = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// CPU bus arbiter: stalls fetch, drains the pipeline, hands the address and
// data bus to DMA or UART for a bounded burst, then guarantees the CPU a
// minimum number of owned cycles before the next arbitration.
//
// Handshake: a requester holds its REQ bit high until it is done; GNT for
// that bit goes high no earlier than DRAIN_CYC edges after REQ is first
// sampled, and drops one edge after REQ is sampled low (or at burst limit).
// All outputs are flops loaded from the next-state decode, so they never
// depend combinationally on inputs.
module bus_arbiter
    import cpu_bus_pkg::*;
#(
    parameter int DRAIN_CYC = DRAIN_CYC_DEFAULT,
    parameter int MAX_BURST = MAX_BURST_DEFAULT,
    parameter int CPU_MIN   = CPU_MIN_DEFAULT
) (
    input  logic       MAINCLK,
    input  logic       MAINRST,
    input  logic       PIPE_MEMBUSY,
    input  logic [1:0] REQ,
    output logic [1:0] GNT,
    output logic       FETCH_SUPPRESS,
    output logic       ADDR_OWN,
    output logic [2:0] ARB_STATE
);

    localparam int CW = cnt_width(MAX_BURST, CPU_MIN, DRAIN_CYC);

    // Terminal counts: a phase of N cycles ends when the counter reads N-1.
    localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_CYC - 1);
    localparam logic [CW-1:0] BURST_LAST = CW'(MAX_BURST - 1);
    localparam logic [CW-1:0] HOLD_LAST  = CW'(CPU_MIN - 1);
    localparam logic [CW-1:0] CNT_MAX    = {CW{1'b1}};

    arb_state_e    state;
    arb_state_e    state_next;
    logic [CW-1:0] cnt;
    logic          ptr;
    logic [1:0]    winner;
    logic [1:0]    pick;
    logic          arb_fire;
    logic [1:0]    gnt_next;
    logic          fs_next;
    logic          own_next;
    logic [1:0]    gnt_q;
    logic          fs_q;
    logic          own_q;

    rr_arb2 u_rr (
        .req    (REQ),
        .ptr    (ptr),
        .update (arb_fire),
        .gnt    (pick)
    );

    // Next-state selection and decode of the outputs for the next state.
    always_comb begin
        state_next = state;
        arb_fire   = 1'b0;
        gnt_next   = 2'b00;
        fs_next    = 1'b0;
        own_next   = 1'b0;

        case (state)
            ST_CPU: begin
                if (REQ != 2'b00) state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (REQ == 2'b00) begin
                    state_next = ST_RELEASE;
                end else if (cnt >= DRAIN_LAST && !PIPE_MEMBUSY) begin
                    state_next = ST_GRANT;
                    arb_fire   = 1'b1;
                end
            end
            ST_GRANT: begin
                // Only the owner's request matters; the other bit is ignored.
                if ((REQ & winner) == 2'b00 || cnt >= BURST_LAST) begin
                    state_next = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                state_next = ST_HOLDOFF;
            end
            ST_HOLDOFF: begin
                if (cnt >= HOLD_LAST) state_next = ST_CPU;
            end
            default: begin
                state_next = ST_CPU;
            end
        endcase

        case (state_next)
            ST_DRAIN, ST_RELEASE: begin
                fs_next = 1'b1;
            end
            ST_GRANT: begin
                fs_next  = 1'b1;
                own_next = 1'b1;
                gnt_next = arb_fire ? pick : winner;
            end
            default: begin
                fs_next = 1'b0;
            end
        endcase
    end

    // State register and saturating phase counter, cleared on every entry.
    always_ff @(posedge MAINCLK) begin
        if (MAINRST) begin
            state <= ST_CPU;
            cnt   <= '0;
        end else begin
            state <= state_next;
            if (state_next != state) cnt <= '0;
            else if (cnt != CNT_MAX)  cnt <= cnt + 1'b1;
        end
    end

    // Winner / round-robin pointer capture and registered outputs.
    always_ff @(posedge MAINCLK) begin
        if (MAINRST) begin
            ptr    <= 1'b1;
            winner <= 2'b00;
            gnt_q  <= 2'b00;
            fs_q   <= 1'b0;
            own_q  <= 1'b0;
        end else begin
            if (arb_fire) begin
                winner <= pick;
                ptr    <= pick[REQ_UART];
            end
            gnt_q <= gnt_next;
            fs_q  <= fs_next;
            own_q <= own_next;
        end
    end

    assign GNT            = gnt_q;
    assign FETCH_SUPPRESS = fs_q;
    assign ADDR_OWN       = own_q;
    assign ARB_STATE      = state;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed scenarios plus randomized request
// scenarios predicted by a timeline model built from tenure arithmetic.
module tb_bus_arbiter;
    import cpu_bus_pkg::*;

    localparam int DC = DRAIN_CYC_DEFAULT;
    localparam int MB = MAX_BURST_DEFAULT;
    localparam int CM = CPU_MIN_DEFAULT;
    localparam int TL = 512;

    logic       MAINCLK;
    logic       MAINRST;
    logic       PIPE_MEMBUSY;
    logic [1:0] REQ;
    logic [1:0] GNT;
    logic       FETCH_SUPPRESS;
    logic       ADDR_OWN;
    logic [2:0] ARB_STATE;

    int checks;
    int errors;
    int last_idx;   // model: index of requester granted most recently

    bus_arbiter dut (
        .MAINCLK        (MAINCLK),
        .MAINRST        (MAINRST),
        .PIPE_MEMBUSY   (PIPE_MEMBUSY),
        .REQ            (REQ),
        .GNT            (GNT),
        .FETCH_SUPPRESS (FETCH_SUPPRESS),
        .ADDR_OWN       (ADDR_OWN),
        .ARB_STATE      (ARB_STATE)
    );

    // Clock
    initial begin
        MAINCLK = 1'b0;
        forever #5 MAINCLK = ~MAINCLK;
    end

    // Watchdog
    initial begin
        #1000000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog");
    end

    // Advance one edge, sample after it, and check the grant invariants.
    task automatic tick();
        @(posedge MAINCLK);
        #1;
        checks++;
        if ($countones(GNT) > 1 || (GNT != 2'b00 && (!FETCH_SUPPRESS || !ADDR_OWN))) begin
            errors++;
            $display("FAIL invariant: gnt=%b fs=%b own=%b", GNT, FETCH_SUPPRESS, ADDR_OWN);
        end
    endtask

    task automatic do_reset();
        MAINRST      = 1'b1;
        REQ          = 2'b00;
        PIPE_MEMBUSY = 1'b0;
        tick();
        tick();
        MAINRST  = 1'b0;
        last_idx = 1;
    endtask

    // Build the expected timeline of a request scenario from tenure
    // arithmetic, then drive it and compare every cycle. Requester i keeps
    // REQ high until it has received n_i granted cycles in total.
    task automatic run_scenario(input logic [1:0] mask, input int n0, input int n1, input int b);
        logic [1:0] eg[TL];
        logic       ef[TL];
        logic       eo[TL];
        logic [2:0] es[TL];
        int rem[2];
        int end_e[2];
        int t, g, len, r, w, last_e, wait_c;
        logic [1:0] req_v;

        for (int e = 0; e < TL; e++) begin
            eg[e] = 2'b00; ef[e] = 1'b0; eo[e] = 1'b0; es[e] = ST_CPU;
        end
        rem[0] = mask[0] ? n0 : 0;
        rem[1] = mask[1] ? n1 : 0;
        end_e[0] = 0;
        end_e[1] = 0;
        t = 0;
        last_e = 0;
        while (rem[0] > 0 || rem[1] > 0) begin
            wait_c = (t == 0 && b > DC) ? b : DC;
            g = t + wait_c;
            for (int e = t; e < g; e++) begin ef[e] = 1'b1; es[e] = ST_DRAIN; end
            if (rem[0] > 0 && rem[1] > 0) w = (last_idx == 0) ? 1 : 0;
            else                          w = (rem[0] > 0) ? 0 : 1;
            len = (rem[w] < MB) ? rem[w] : MB;
            for (int e = g; e < g + len; e++) begin
                eg[e] = 2'(1 << w); eo[e] = 1'b1; ef[e] = 1'b1; es[e] = ST_GRANT;
            end
            rem[w] -= len;
            if (rem[w] == 0) end_e[w] = g + len;
            last_idx = w;
            r = g + len;
            ef[r] = 1'b1;
            es[r] = ST_RELEASE;
            for (int e = r + 1; e <= r + CM; e++) es[e] = ST_HOLDOFF;
            last_e = r + CM + 1;
            t = last_e + 1;
        end

        for (int e = 0; e <= last_e; e++) begin
            req_v[0] = mask[0] && (e < end_e[0]);
            req_v[1] = mask[1] && (e < end_e[1]);
            REQ = req_v;
            PIPE_MEMBUSY = (e < b);
            tick();
            checks++;
            if (GNT !== eg[e]) begin
                errors++;
                $display("FAIL scen_gnt e=%0d got=%b exp=%b", e, GNT, eg[e]);
            end
            checks++;
            if (FETCH_SUPPRESS !== ef[e]) begin
                errors++;
                $display("FAIL scen_fs e=%0d got=%b exp=%b", e, FETCH_SUPPRESS, ef[e]);
            end
            checks++;
            if (ADDR_OWN !== eo[e]) begin
                errors++;
                $display("FAIL scen_own e=%0d got=%b exp=%b", e, ADDR_OWN, eo[e]);
            end
            checks++;
            if (ARB_STATE !== es[e]) begin
                errors++;
                $display("FAIL scen_state e=%0d got=%0d exp=%0d", e, ARB_STATE, es[e]);
            end
        end
        REQ = 2'b00;
        PIPE_MEMBUSY = 1'b0;
    endtask

    task automatic test_reset();
        MAINRST = 1'b1;
        REQ = 2'b11;          // reset must override requests
        PIPE_MEMBUSY = 1'b1;
        tick();
        tick();
        checks++;
        if (GNT !== 2'b00 || FETCH_SUPPRESS !== 1'b0 || ADDR_OWN !== 1'b0 || ARB_STATE !== ST_CPU) begin
            errors++;
            $display("FAIL reset: gnt=%b fs=%b own=%b st=%0d exp 00/0/0/0", GNT, FETCH_SUPPRESS, ADDR_OWN, ARB_STATE);
        end
        MAINRST = 1'b0;
        REQ = 2'b00;
        PIPE_MEMBUSY = 1'b0;
        last_idx = 1;
        tick();
        checks++;
        if (ARB_STATE !== ST_CPU || FETCH_SUPPRESS !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: st=%0d fs=%b exp 0/0", ARB_STATE, FETCH_SUPPRESS);
        end
    endtask

    task automatic test_first_grant();
        do_reset();
        REQ = 2'b01;
        tick();
        checks++;
        if (FETCH_SUPPRESS !== 1'b1 || GNT !== 2'b00 || ARB_STATE !== ST_DRAIN) begin
            errors++;
            $display("FAIL first_drain: fs=%b gnt=%b st=%0d exp 1/00/1", FETCH_SUPPRESS, GNT, ARB_STATE);
        end
        tick();
        checks++;
        if (GNT !== 2'b00) begin
            errors++;
            $display("FAIL first_early_gnt: gnt=%b exp 00", GNT);
        end
        tick();
        checks++;
        if (GNT !== 2'b01 || ADDR_OWN !== 1'b1) begin
            errors++;
            $display("FAIL first_gnt: gnt=%b own=%b exp 01/1", GNT, ADDR_OWN);
        end
        last_idx = 0;
        tick();
        tick();
        REQ = 2'b00;
        tick();
        checks++;
        if (GNT !== 2'b00 || ADDR_OWN !== 1'b0 || FETCH_SUPPRESS !== 1'b1 || ARB_STATE !== ST_RELEASE) begin
            errors++;
            $display("FAIL first_release: gnt=%b own=%b fs=%b st=%0d exp 00/0/1/3", GNT, ADDR_OWN, FETCH_SUPPRESS, ARB_STATE);
        end
        for (int i = 0; i < CM; i++) begin
            tick();
            checks++;
            if (ARB_STATE !== ST_HOLDOFF || FETCH_SUPPRESS !== 1'b0) begin
                errors++;
                $display("FAIL first_holdoff%0d: st=%0d fs=%b exp 4/0", i, ARB_STATE, FETCH_SUPPRESS);
            end
        end
        tick();
        checks++;
        if (ARB_STATE !== ST_CPU) begin
            errors++;
            $display("FAIL first_cpu: st=%0d exp 0", ARB_STATE);
        end
    endtask

    task automatic test_tie_alternation();
        do_reset();
        run_scenario(2'b11, 3 * MB, 3 * MB, 0);
    endtask

    task automatic test_membusy();
        do_reset();
        run_scenario(2'b10, 0, 6, 5);
    endtask

    task automatic test_drain_abort();
        do_reset();
        REQ = 2'b01;
        tick();
        checks++;
        if (ARB_STATE !== ST_DRAIN) begin
            errors++;
            $display("FAIL abort_drain: st=%0d exp 1", ARB_STATE);
        end
        REQ = 2'b00;
        tick();
        checks++;
        if (ARB_STATE !== ST_RELEASE || GNT !== 2'b00) begin
            errors++;
            $display("FAIL abort_release: st=%0d gnt=%b exp 3/00", ARB_STATE, GNT);
        end
        for (int i = 0; i < CM; i++) begin
            tick();
            checks++;
            if (ARB_STATE !== ST_HOLDOFF || GNT !== 2'b00) begin
                errors++;
                $display("FAIL abort_holdoff%0d: st=%0d gnt=%b exp 4/00", i, ARB_STATE, GNT);
            end
        end
        tick();
        checks++;
        if (ARB_STATE !== ST_CPU || GNT !== 2'b00) begin
            errors++;
            $display("FAIL abort_cpu: st=%0d gnt=%b exp 0/00", ARB_STATE, GNT);
        end
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        REQ = 2'b01;
        for (int i = 0; i < DC + 7; i++) tick();
        checks++;
        if (GNT !== 2'b01) begin
            errors++;
            $display("FAIL midgrant_pre: gnt=%b exp 01", GNT);
        end
        MAINRST = 1'b1;
        tick();
        checks++;
        if (GNT !== 2'b00 || ADDR_OWN !== 1'b0 || FETCH_SUPPRESS !== 1'b0 || ARB_STATE !== ST_CPU) begin
            errors++;
            $display("FAIL midgrant_reset: gnt=%b own=%b fs=%b st=%0d exp 00/0/0/0", GNT, ADDR_OWN, FETCH_SUPPRESS, ARB_STATE);
        end
        MAINRST = 1'b0;
        REQ = 2'b00;
        last_idx = 1;
        tick();
        run_scenario(2'b11, 4, 4, 0);
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 25; k++) begin
            run_scenario(2'($urandom_range(1, 3)), int'($urandom_range(1, 40)),
                         int'($urandom_range(1, 40)), int'($urandom_range(0, 5)));
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        last_idx = 1;
        MAINRST = 1'b1;
        REQ = 2'b00;
        PIPE_MEMBUSY = 1'b0;
        test_reset();
        test_first_grant();
        test_tie_alternation();
        test_membusy();
        test_drain_abort();
        test_reset_mid_grant();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 The block SHALL have parameter DRAIN_CYC, default 2, setting the minimum number of pipeline-drain cycles before a grant.
REQ-002 The block SHALL have parameter MAX_BURST, default 16, setting the maximum number of consecutive granted cycles per tenure.
REQ-003 The block SHALL have parameter CPU_MIN, default 4, setting the minimum number of CPU-owned cycles after each release.
REQ-004 The block SHALL have port MAINCLK, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-005 The block SHALL have port MAINRST, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port PIPE_MEMBUSY, input, 1 bit: the pipeline has a memory access in flight.
REQ-007 The block SHALL have port REQ, input, 2 bits: external bus requests; [0] is DMA, [1] is UART.
REQ-008 The block SHALL have port GNT, output, 2 bits: one-hot grant matching the REQ bit order.
REQ-009 The block SHALL have port FETCH_SUPPRESS, output, 1 bit: high stalls the pipeline's instruction fetch.
REQ-010 The block SHALL have port ADDR_OWN, output, 1 bit: high means the external master drives ADDRBUS and MEMDATA.
REQ-011 The block SHALL have port ARB_STATE, output, 3 bits: current state encoding, for debug.

Function
REQ-012 All outputs SHALL be registered and be a decode of the state register only; no input-to-output combinational path.
REQ-013 The block SHALL have exactly five states: CPU, DRAIN, GRANT, RELEASE and HOLDOFF.
REQ-014 CPU: FETCH_SUPPRESS=0, GNT=0, ADDR_OWN=0; any REQ bit high SHALL cause a move to DRAIN on the next edge.
REQ-015 DRAIN: FETCH_SUPPRESS=1 and the drain counter increments each cycle.
REQ-016 DRAIN SHALL move to GRANT when the drain counter is at least DRAIN_CYC-1 and PIPE_MEMBUSY=0; while PIPE_MEMBUSY=1 it SHALL stay in DRAIN.
REQ-017 If REQ falls to 0 during DRAIN, the block SHALL move to RELEASE and issue no grant.
REQ-018 The winner SHALL be chosen on the DRAIN-to-GRANT edge: a single requester wins outright; if both request, the one not granted last wins (round-robin pointer).
REQ-019 The round-robin pointer SHALL reset to 1, so DMA wins the first tie.
REQ-020 GRANT: GNT = one-hot winner, ADDR_OWN=1, FETCH_SUPPRESS=1, and the burst counter increments each cycle.
REQ-021 GRANT SHALL move to RELEASE when REQ[winner]=0, or when the burst counter reaches MAX_BURST-1 (forced preemption), whichever occurs first.
REQ-022 In GRANT, the other requester's REQ SHALL be ignored.
REQ-023 RELEASE SHALL last exactly 1 cycle as bus turnaround: GNT=0, ADDR_OWN=0, FETCH_SUPPRESS=1; then move to HOLDOFF.
REQ-024 HOLDOFF: FETCH_SUPPRESS=0; REQ SHALL be ignored for CPU_MIN cycles, then the block moves to CPU.
REQ-025 In HOLDOFF, a pending REQ SHALL NOT shorten the hold; the block re-arbitrates only from CPU.
REQ-026 Latency: with REQ first sampled high at edge k, FETCH_SUPPRESS is high after edge k.
REQ-027 Latency: GNT SHALL rise after edge k+DRAIN_CYC at the earliest.
REQ-028 Latency: after REQ[winner] falls at edge m, GNT SHALL fall after edge m.
REQ-029 Counters SHALL be sized as clog2(max(MAX_BURST, CPU_MIN, DRAIN_CYC)) + 1 bits, SHALL saturate and never wrap, and SHALL clear on every state entry.
REQ-030 GNT SHALL never have more than one bit set, and GNT!=0 SHALL imply ADDR_OWN=1 and FETCH_SUPPRESS=1.

Reset
REQ-031 MAINRST=1 at an edge SHALL force state CPU, all counters 0, round-robin pointer 1, and GNT=0, ADDR_OWN=0, FETCH_SUPPRESS=0.
REQ-032 Reset asserted mid-GRANT SHALL drop the grant with no RELEASE or HOLDOFF cycle.
REQ-033 MAINRST SHALL override all other inputs.

Structure
REQ-034 Package cpu_bus_pkg SHALL hold the state enumeration and encoding, the requester index constants (REQ_DMA=0, REQ_UART=1), and the parameter defaults.
REQ-035 The 2-way round-robin picker SHALL be one sub-module, rr_arb2, with inputs req[1:0], ptr and update, and output gnt[1:0]; all other logic SHALL be inline.

Verification
REQ-036 Reset then REQ=01 held, PIPE_MEMBUSY=0 -> FETCH_SUPPRESS=1 one cycle later, GNT=01 and ADDR_OWN=1 three cycles after REQ.
REQ-037 REQ=11 held continuously -> grants alternate 01, 10, 01, each exactly 16 cycles, separated by 1 RELEASE cycle and 4 HOLDOFF cycles.
REQ-038 REQ=10 with PIPE_MEMBUSY=1 for 5 cycles -> stays in DRAIN, GNT=0 until PIPE_MEMBUSY falls, then GNT=10 the next cycle.
REQ-039 REQ=01 pulses for 1 cycle during DRAIN -> RELEASE, HOLDOFF, then CPU; GNT stays 00 throughout.
REQ-040 MAINRST=1 on the 7th GRANT cycle -> next cycle all outputs 0 and state CPU; a subsequent REQ=11 tie grants DMA (01) first.
REQ-041 Assertion check over all tests: GNT one-hot-or-zero, and GNT!=0 implies FETCH_SUPPRESS=1.
